// File: rtl/axi_lite_mem_arbiter.sv
// rtl/axi_lite_mem_arbiter.sv - Whole-transaction arbiter sharing one AXI-Lite port between IFU and LSU
// Grant is registered in IDLE; all channels of the granted master are routed combinationally downstream.

module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic [2:0]            ifu_arsize,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,

    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic [2:0]            lsu_arsize,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic [2:0]            lsu_awsize,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [1:0]            lsu_bresp,

    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [2:0]            m_arsize,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [2:0]            m_awsize,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } state_t;

    state_t state_q;
    state_t grant_d;
    logic   ar_done_q;
    logic   aw_done_q;
    logic   w_done_q;
    logic   last_rd_lsu_q;
    logic   busy_q;

    logic   ar_hs;
    logic   r_hs;
    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;

    // Writes always win; read contention is fixed-LSU or alternates on the last read served.
    always_comb begin
        grant_d = IDLE;
        if (lsu_awvalid || lsu_wvalid) begin
            grant_d = WR_LSU;
        end else if (lsu_arvalid && ifu_arvalid) begin
            if ((RR_EN != 0) && last_rd_lsu_q) begin
                grant_d = RD_IFU;
            end else begin
                grant_d = RD_LSU;
            end
        end else if (lsu_arvalid) begin
            grant_d = RD_LSU;
        end else if (ifu_arvalid) begin
            grant_d = RD_IFU;
        end
    end

    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid  & m_rready;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bvalid  & m_bready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ar_done_q     <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            last_rd_lsu_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d != IDLE) begin
                        state_q <= grant_d;
                        busy_q  <= 1'b1;
                        if (grant_d == RD_LSU) begin
                            last_rd_lsu_q <= 1'b1;
                        end else if (grant_d == RD_IFU) begin
                            last_rd_lsu_q <= 1'b0;
                        end
                    end
                end
                RD_IFU, RD_LSU: begin
                    if (ar_hs) begin
                        ar_done_q <= 1'b1;
                    end
                    if (r_hs) begin
                        state_q   <= IDLE;
                        ar_done_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                WR_LSU: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done_q <= 1'b1;
                    end
                    if (b_hs) begin
                        state_q   <= IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // Everything not belonging to the granted transaction is held at zero, so stray slave
    // responses never reach a master and the slave never sees a ready it was not granted.
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = 2'b00;
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_arsize    = 3'd0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_awaddr    = '0;
        m_awsize    = 3'd0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_bready    = 1'b0;
        case (state_q)
            RD_IFU: begin
                m_arvalid   = ifu_arvalid & ~ar_done_q;
                m_araddr    = ifu_araddr;
                m_arsize    = ifu_arsize;
                ifu_arready = m_arready & ~ar_done_q;
                ifu_rvalid  = m_rvalid;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                m_rready    = ifu_rready;
            end
            RD_LSU: begin
                m_arvalid   = lsu_arvalid & ~ar_done_q;
                m_araddr    = lsu_araddr;
                m_arsize    = lsu_arsize;
                lsu_arready = m_arready & ~ar_done_q;
                lsu_rvalid  = m_rvalid;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
                m_rready    = lsu_rready;
            end
            WR_LSU: begin
                m_awvalid   = lsu_awvalid & ~aw_done_q;
                m_awaddr    = lsu_awaddr;
                m_awsize    = lsu_awsize;
                lsu_awready = m_awready & ~aw_done_q;
                m_wvalid    = lsu_wvalid & ~w_done_q;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                lsu_wready  = m_wready & ~w_done_q;
                lsu_bvalid  = m_bvalid;
                lsu_bresp   = m_bresp;
                m_bready    = lsu_bready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb/tb_axi_lite_mem_arbiter.sv - Directed self-checking bench for axi_lite_mem_arbiter
// Two instances share stimulus: fixed priority (dut0) and round-robin (dut_rr).

module tb_axi_lite_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ifu_arvalid = 0, ifu_rready = 0;
    logic [31:0] ifu_araddr = 0;
    logic [2:0]  ifu_arsize = 0;
    logic        lsu_arvalid = 0, lsu_rready = 0, lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
    logic [31:0] lsu_araddr = 0, lsu_awaddr = 0, lsu_wdata = 0;
    logic [2:0]  lsu_arsize = 0, lsu_awsize = 0;
    logic [3:0]  lsu_wstrb = 0;
    logic        m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
    logic [31:0] m_rdata = 0;
    logic [1:0]  m_rresp = 0, m_bresp = 0;

    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
    logic [31:0] ifu_rdata, lsu_rdata, m_araddr, m_awaddr, m_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, busy;
    logic [2:0]  m_arsize, m_awsize;
    logic [3:0]  m_wstrb;

    logic        rr_ifu_arready, rr_ifu_rvalid, rr_lsu_arready, rr_lsu_rvalid, rr_lsu_awready, rr_lsu_wready, rr_lsu_bvalid;
    logic [31:0] rr_ifu_rdata, rr_lsu_rdata, rr_m_araddr, rr_m_awaddr, rr_m_wdata;
    logic [1:0]  rr_ifu_rresp, rr_lsu_rresp, rr_lsu_bresp;
    logic        rr_m_arvalid, rr_m_rready, rr_m_awvalid, rr_m_wvalid, rr_m_bready, rr_busy;
    logic [2:0]  rr_m_arsize, rr_m_awsize;
    logic [3:0]  rr_m_wstrb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut0 (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arsize(m_arsize),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .busy(busy)
    );

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(rr_ifu_arready), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize),
        .ifu_rvalid(rr_ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(rr_ifu_rdata), .ifu_rresp(rr_ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(rr_lsu_arready), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_rvalid(rr_lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(rr_lsu_rdata), .lsu_rresp(rr_lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(rr_lsu_awready), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(rr_lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_bvalid(rr_lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(rr_lsu_bresp),
        .m_arvalid(rr_m_arvalid), .m_arready(m_arready), .m_araddr(rr_m_araddr), .m_arsize(rr_m_arsize),
        .m_rvalid(m_rvalid), .m_rready(rr_m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(rr_m_awvalid), .m_awready(m_awready), .m_awaddr(rr_m_awaddr), .m_awsize(rr_m_awsize),
        .m_wvalid(rr_m_wvalid), .m_wready(m_wready), .m_wdata(rr_m_wdata), .m_wstrb(rr_m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(rr_m_bready), .m_bresp(m_bresp),
        .busy(rr_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic test_reset;
        ifu_arvalid = 1'b1;
        ifu_araddr  = 32'h3000_0000;
        m_arready   = 1'b1;
        m_rvalid    = 1'b1;
        m_bvalid    = 1'b1;
        tick();
        sample();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b exp 0", busy); end
        vectors++; if (m_arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_arvalid got %0b exp 0", m_arvalid); end
        vectors++; if (ifu_arready !== 1'b0) begin miscompares++; $display("FAIL reset_ifu_arready got %0b exp 0", ifu_arready); end
        vectors++; if (m_araddr !== 32'h0) begin miscompares++; $display("FAIL reset_m_araddr got %h exp 0", m_araddr); end
        vectors++; if ({ifu_rvalid, lsu_bvalid, m_rready, m_bready} !== 4'b0000) begin miscompares++; $display("FAIL reset_vr got %b exp 0000", {ifu_rvalid, lsu_bvalid, m_rready, m_bready}); end
        tick();
        rst = 1'b0; ifu_arvalid = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0;
        tick();
    endtask

    task automatic test_ifu_alone;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arsize = 3'd2; ifu_rready = 1'b1; m_arready = 1'b1;
        sample();
        vectors++; if (ifu_arready !== 1'b0) begin miscompares++; $display("FAIL ifu_idle_arready got %0b exp 0", ifu_arready); end
        tick();
        sample();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ifu_grant_busy got %0b exp 1", busy); end
        vectors++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h3000_0000) begin miscompares++; $display("FAIL ifu_fwd_ar got %0b/%h exp 1/30000000", m_arvalid, m_araddr); end
        vectors++; if (ifu_arready !== 1'b1) begin miscompares++; $display("FAIL ifu_arready got %0b exp 1", ifu_arready); end
        tick();
        sample();
        vectors++; if (m_arvalid !== 1'b0 || ifu_arready !== 1'b0) begin miscompares++; $display("FAIL ifu_ar_done got %0b/%0b exp 0/0", m_arvalid, ifu_arready); end
        tick();
        ifu_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0413; m_rresp = 2'b00;
        sample();
        vectors++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || ifu_rresp !== 2'b00) begin miscompares++; $display("FAIL ifu_r got %0b/%h/%0d exp 1/00000413/0", ifu_rvalid, ifu_rdata, ifu_rresp); end
        vectors++; if (m_rready !== 1'b1 || lsu_rvalid !== 1'b0) begin miscompares++; $display("FAIL ifu_rready got %0b/%0b exp 1/0", m_rready, lsu_rvalid); end
        tick();
        m_rvalid = 1'b0;
        sample();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ifu_end_busy got %0b exp 0", busy); end
    endtask

    task automatic test_simul_fixed;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0004;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0010; lsu_arsize = 3'd2; lsu_rready = 1'b1;
        tick();
        sample();
        vectors++; if (lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin miscompares++; $display("FAIL fix_first got lsu %0b ifu %0b exp 1/0", lsu_arready, ifu_arready); end
        vectors++; if (m_araddr !== 32'h0F00_0010) begin miscompares++; $display("FAIL fix_addr1 got %h exp 0f000010", m_araddr); end
        tick();
        lsu_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_1111;
        sample();
        vectors++; if (lsu_rdata !== 32'h1111_1111 || ifu_rvalid !== 1'b0 || ifu_arready !== 1'b0) begin miscompares++; $display("FAIL fix_lsu_r got %h/%0b/%0b exp 11111111/0/0", lsu_rdata, ifu_rvalid, ifu_arready); end
        tick();
        m_rvalid = 1'b0;
        sample();
        vectors++; if (ifu_arready !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL fix_idle_gap got %0b/%0b exp 0/0", ifu_arready, busy); end
        tick();
        sample();
        vectors++; if (ifu_arready !== 1'b1 || m_araddr !== 32'h3000_0004) begin miscompares++; $display("FAIL fix_second got %0b/%h exp 1/30000004", ifu_arready, m_araddr); end
        tick();
        ifu_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2222_2222;
        sample();
        vectors++; if (ifu_rdata !== 32'h2222_2222 || lsu_rvalid !== 1'b0) begin miscompares++; $display("FAIL fix_ifu_r got %h/%0b exp 22222222/0", ifu_rdata, lsu_rvalid); end
        tick();
        m_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_write;
        int wpulses = 0;
        int apulses = 0;
        lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; lsu_bready = 1'b1;
        m_wready = 1'b1; m_awready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            sample();
            wpulses += int'(m_wvalid);
            apulses += int'(m_awvalid);
            if (c == 1) begin
                vectors++; if (m_wdata !== 32'hDEAD_BEEF || m_wstrb !== 4'b0011 || m_awvalid !== 1'b0) begin miscompares++; $display("FAIL wr_w got %h/%b/%0b exp deadbeef/0011/0", m_wdata, m_wstrb, m_awvalid); end
            end
            if (c == 2) begin
                vectors++; if (m_awvalid !== 1'b1 || m_awaddr !== 32'h1000_0000 || lsu_wready !== 1'b0) begin miscompares++; $display("FAIL wr_aw got %0b/%h/%0b exp 1/10000000/0", m_awvalid, m_awaddr, lsu_wready); end
            end
            if (c == 3) begin
                vectors++; if (m_awvalid !== 1'b0 || lsu_awready !== 1'b0) begin miscompares++; $display("FAIL wr_aw_done got %0b/%0b exp 0/0", m_awvalid, lsu_awready); end
            end
            if (c == 4) begin
                vectors++; if (lsu_bvalid !== 1'b1 || lsu_bresp !== 2'b00 || m_bready !== 1'b1) begin miscompares++; $display("FAIL wr_b got %0b/%0d/%0b exp 1/0/1", lsu_bvalid, lsu_bresp, m_bready); end
            end
            if (c == 5) begin
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_end_busy got %0b exp 0", busy); end
            end
            tick();
            case (c)
                1: begin lsu_wvalid = 1'b0; lsu_awvalid = 1'b1; lsu_awaddr = 32'h1000_0000; lsu_awsize = 3'd2; end
                3: begin lsu_awvalid = 1'b0; m_bvalid = 1'b1; m_bresp = 2'b00; end
                4: m_bvalid = 1'b0;
                default: ;
            endcase
        end
        vectors++; if (wpulses != 1) begin miscompares++; $display("FAIL wr_wpulses got %0d exp 1", wpulses); end
        vectors++; if (apulses != 1) begin miscompares++; $display("FAIL wr_awpulses got %0d exp 1", apulses); end
    endtask

    task automatic test_err_spurious;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0008; m_bvalid = 1'b1; m_bresp = 2'b10;
        sample();
        vectors++; if (lsu_bvalid !== 1'b0) begin miscompares++; $display("FAIL sp_idle_bvalid got %0b exp 0", lsu_bvalid); end
        tick();
        sample();
        vectors++; if (lsu_bvalid !== 1'b0 || m_bready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL sp_rd_b got %0b/%0b/%0b exp 0/0/1", lsu_bvalid, m_bready, busy); end
        tick();
        ifu_arvalid = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b1; m_rresp = 2'b11; m_rdata = 32'hCAFE_0000;
        sample();
        vectors++; if (ifu_rvalid !== 1'b1 || ifu_rresp !== 2'b11) begin miscompares++; $display("FAIL err_rresp got %0b/%0d exp 1/3", ifu_rvalid, ifu_rresp); end
        tick();
        sample();
        vectors++; if (busy !== 1'b0 || ifu_rvalid !== 1'b0 || m_rready !== 1'b0) begin miscompares++; $display("FAIL err_idle got %0b/%0b/%0b exp 0/0/0", busy, ifu_rvalid, m_rready); end
        tick();
        m_rvalid = 1'b0; m_rresp = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0020;
        tick();
        sample();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rm_busy got %0b exp 1", busy); end
        tick();
        lsu_arvalid = 1'b0;
        sample();
        vectors++; if (m_rready !== 1'b1) begin miscompares++; $display("FAIL rm_rready got %0b exp 1", m_rready); end
        #1;
        rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h5555_5555;
        #1;
        vectors++; if (busy !== 1'b0 || m_rready !== 1'b0 || lsu_rvalid !== 1'b0) begin miscompares++; $display("FAIL rm_async got %0b/%0b/%0b exp 0/0/0", busy, m_rready, lsu_rvalid); end
        vectors++; if ({m_arvalid, lsu_arready, ifu_arready, m_awvalid, m_wvalid, m_bready} !== 6'b0) begin miscompares++; $display("FAIL rm_vr got %b exp 000000", {m_arvalid, lsu_arready, ifu_arready, m_awvalid, m_wvalid, m_bready}); end
        tick();
        rst = 1'b0; m_rvalid = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0010;
        tick();
        sample();
        vectors++; if (m_araddr !== 32'h3000_0010 || ifu_arready !== 1'b1) begin miscompares++; $display("FAIL rm_new_ar got %h/%0b exp 30000010/1", m_araddr, ifu_arready); end
        tick();
        ifu_arvalid = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00A0_0093;
        sample();
        vectors++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h00A0_0093) begin miscompares++; $display("FAIL rm_new_r got %0b/%h exp 1/00a00093", ifu_rvalid, ifu_rdata); end
        tick();
        m_rvalid = 1'b0;
        sample();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_new_end got %0b exp 0", busy); end
        tick();
    endtask

    task automatic test_round_robin;
        logic win_ifu;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // A lone LSU read makes the LSU the last-served reader before the contests start.
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0030;
        tick();
        tick();
        lsu_arvalid = 1'b0; m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            win_ifu = ((k % 2) == 0);
            tick();
            sample();
            vectors++; if (rr_ifu_arready !== win_ifu || rr_lsu_arready !== !win_ifu) begin miscompares++; $display("FAIL rr_grant%0d got ifu %0b lsu %0b exp ifu %0b", k, rr_ifu_arready, rr_lsu_arready, win_ifu); end
            tick();
            if (win_ifu) ifu_arvalid = 1'b0; else lsu_arvalid = 1'b0;
            m_rvalid = 1'b1;
            tick();
            m_rvalid = 1'b0;
            if (k < 3) begin
                if (win_ifu) ifu_arvalid = 1'b1; else lsu_arvalid = 1'b1;
            end
        end
        sample();
        vectors++; if (rr_busy !== 1'b0) begin miscompares++; $display("FAIL rr_end_busy got %0b exp 0", rr_busy); end
    endtask

    initial begin
        test_reset();
        test_ifu_alone();
        test_simul_fixed();
        test_write();
        test_err_spurious();
        test_reset_mid();
        test_round_robin();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
